// File: rtl/mini_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_core_pkg
// Description : Opcodes, FSM states and instruction-width helper for mini core.
// Revision    : 1.0
// ============================================================================
package mini_core_pkg;

  localparam logic [1:0] c_op_add  = 2'b00;
  localparam logic [1:0] c_op_sub  = 2'b01;
  localparam logic [1:0] c_op_mul  = 2'b10;
  localparam logic [1:0] c_op_halt = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Instruction = 2-bit opcode followed by src1, src2 and dst addresses.
  function automatic int calc_iw(input int aw);
    return 2 + 3 * aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mc_mul_iter
// Description : Shift-add multiplier, one multiplier bit per cycle, DW cycles.
// Revision    : 1.0
// ============================================================================
module mc_mul_iter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] p
);

  localparam int c_cnt_w = $clog2(DW + 1);

  logic [DW-1:0]      r_mcand;
  logic [DW-1:0]      r_mplier;
  logic [DW-1:0]      r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic [DW-1:0]      w_sum;

  // The final partial sum is exposed combinationally so the product is usable
  // in the last of the DW cycles rather than one cycle later.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign p     = w_sum;
  assign done  = (r_cnt == c_cnt_w'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= c_cnt_w'(DW);
    end else if (r_cnt != '0) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mini_core_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mini_core_pipe
// Description : IF/LD/EX/WB memory-to-memory core with forwarding, iterative MUL.
// Revision    : 1.0
// ============================================================================
module mini_core_pipe
  import mini_core_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int PW = 5,
  localparam int IW = calc_iw(AW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          iload_en,
  input  logic [PW-1:0] iload_addr,
  input  logic [IW-1:0] iload_data,
  input  logic          dload_en,
  input  logic [AW-1:0] dload_addr,
  input  logic [DW-1:0] dload_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   instret,
  output logic [15:0]   cycles
);

  logic [IW-1:0] r_imem [0:(2**PW)-1];
  logic [DW-1:0] r_dmem [0:(2**AW)-1];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pc;

  logic          r_ld_valid;
  logic [IW-1:0] r_ld_ir;
  logic          r_ex_valid;
  logic [1:0]    r_ex_op;
  logic [DW-1:0] r_ex_a;
  logic [DW-1:0] r_ex_b;
  logic [AW-1:0] r_ex_dst;
  logic          r_wb_valid;
  logic [DW-1:0] r_wb_res;
  logic [AW-1:0] r_wb_dst;
  logic [15:0]   r_instret;
  logic [15:0]   r_cycles;

  logic [1:0]    w_ld_op;
  logic [AW-1:0] w_ld_src1, w_ld_src2, w_ld_dst;
  logic [DW-1:0] w_opa, w_opb, w_ex_res, w_mul_p;
  logic          w_mul_done, w_mul_start;
  logic          w_idle_like, w_run, w_stall, w_ex_done;
  logic          w_halt_ld, w_issue, w_fetch;
  logic          w_start_ok, w_iload_ok, w_dload_ok;

  assign w_ld_op   = r_ld_ir[IW-1 -: 2];
  assign w_ld_src1 = r_ld_ir[3*AW-1 -: AW];
  assign w_ld_src2 = r_ld_ir[2*AW-1 -: AW];
  assign w_ld_dst  = r_ld_ir[AW-1:0];

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALTED);
  assign w_run       = (r_state == ST_RUN);
  assign w_start_ok  = start && w_idle_like;
  assign w_iload_ok  = rst && iload_en && w_idle_like;
  assign w_dload_ok  = rst && dload_en && w_idle_like;

  // Any MUL still iterating freezes IF/LD/pc, which also covers the case of a
  // LD source waiting on that MUL's destination.
  assign w_stall     = r_ex_valid && (r_ex_op == c_op_mul) && !w_mul_done;
  assign w_ex_done   = r_ex_valid && !w_stall;
  assign w_halt_ld   = w_run && r_ld_valid && (w_ld_op == c_op_halt);
  assign w_issue     = w_run && r_ld_valid && (w_ld_op != c_op_halt) && !w_stall;
  assign w_fetch     = w_run && !w_stall && !w_halt_ld;
  assign w_mul_start = w_issue && (w_ld_op == c_op_mul);

  always_comb begin
    w_ex_res = '0;
    case (r_ex_op)
      c_op_add: w_ex_res = r_ex_a + r_ex_b;
      c_op_sub: w_ex_res = r_ex_a - r_ex_b;
      c_op_mul: w_ex_res = w_mul_p;
      default:  w_ex_res = '0;
    endcase
  end

  // Operand selection: EX result beats WB result beats the memory array.
  always_comb begin
    w_opa = r_dmem[w_ld_src1];
    if (w_ex_done && (r_ex_dst == w_ld_src1))
      w_opa = w_ex_res;
    else if (r_wb_valid && (r_wb_dst == w_ld_src1))
      w_opa = r_wb_res;
  end

  always_comb begin
    w_opb = r_dmem[w_ld_src2];
    if (w_ex_done && (r_ex_dst == w_ld_src2))
      w_opb = w_ex_res;
    else if (r_wb_valid && (r_wb_dst == w_ld_src2))
      w_opb = r_wb_res;
  end

  mc_mul_iter #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (w_opa),
    .b     (w_opb),
    .done  (w_mul_done),
    .p     (w_mul_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_halt_ld) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!r_ld_valid && !r_ex_valid && !r_wb_valid) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_ld_valid <= 1'b0;
      r_ld_ir    <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= c_op_add;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_dst   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_res   <= '0;
      r_wb_dst   <= '0;
    end else if (w_start_ok) begin
      r_pc       <= '0;
      r_ld_valid <= 1'b0;
      r_ex_valid <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (busy) begin
      // A MUL still iterating sends a bubble to WB.
      r_wb_valid <= w_ex_done;
      r_wb_res   <= w_ex_res;
      r_wb_dst   <= r_ex_dst;
      if (!w_stall) begin
        r_ex_valid <= w_issue;
        r_ex_op    <= w_ld_op;
        r_ex_a     <= w_opa;
        r_ex_b     <= w_opb;
        r_ex_dst   <= w_ld_dst;
      end
      if (w_fetch) begin
        r_ld_valid <= 1'b1;
        r_ld_ir    <= r_imem[r_pc];
        r_pc       <= r_pc + PW'(1);
      end else if (w_halt_ld || !w_stall) begin
        r_ld_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
      r_cycles  <= '0;
    end else begin
      if (r_wb_valid) r_instret <= r_instret + 16'd1;
      if (busy)       r_cycles  <= r_cycles + 16'd1;
    end
  end

  // Memory arrays are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_iload_ok) r_imem[iload_addr] <= iload_data;
  end

  always_ff @(posedge clk) begin
    if (r_wb_valid)      r_dmem[r_wb_dst]   <= r_wb_res;
    else if (w_dload_ok) r_dmem[dload_addr] <= dload_data;
  end

  assign dbg_data = r_dmem[dbg_addr];
  assign instret  = r_instret;
  assign cycles   = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mini_core_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_core_pipe
// Description : Directed and random programs checked against a sequential
//               instruction-level model of the core.
// Revision    : 1.0
// ============================================================================
module tb_mini_core_pipe;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int PW    = 5;
  localparam int IW    = 2 + 3 * AW;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] c_add  = 2'd0;
  localparam logic [1:0] c_sub  = 2'd1;
  localparam logic [1:0] c_mul  = 2'd2;
  localparam logic [1:0] c_halt = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          iload_en = 1'b0;
  logic [PW-1:0] iload_addr = '0;
  logic [IW-1:0] iload_data = '0;
  logic          dload_en = 1'b0;
  logic [AW-1:0] dload_addr = '0;
  logic [DW-1:0] dload_data = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          busy;
  logic          halted;
  logic [15:0]   instret;
  logic [15:0]   cycles;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [15:0]   m_instret = '0;
  logic [IW-1:0] prog_q [$];

  mini_core_pipe #(.DW(DW), .AW(AW), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .iload_en   (iload_en),
    .iload_addr (iload_addr),
    .iload_data (iload_data),
    .dload_en   (dload_en),
    .dload_addr (dload_addr),
    .dload_data (dload_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy       (busy),
    .halted     (halted),
    .instret    (instret),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] enc(input logic [1:0] op, input int s1, input int s2, input int d);
    logic [AW-1:0] a1, a2, ad;
    a1 = AW'(s1);
    a2 = AW'(s2);
    ad = AW'(d);
    return {op, a1, a2, ad};
  endfunction

  task automatic dload(input int a, input logic [DW-1:0] v);
    dload_en   = 1'b1;
    dload_addr = AW'(a);
    dload_data = v;
    tick();
    dload_en   = 1'b0;
    m_mem[a]   = v;
  endtask

  task automatic load_prog();
    foreach (prog_q[i]) begin
      iload_en   = 1'b1;
      iload_addr = PW'(i);
      iload_data = prog_q[i];
      tick();
    end
    iload_en = 1'b0;
  endtask

  // Sequential execution of the program: one instruction fully completes
  // before the next reads memory.
  task automatic model_exec();
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < prog_q.size() && !stop; i++) begin
      logic [IW-1:0] ir;
      logic [1:0]    op;
      int            x, y, d, r;
      ir = prog_q[i];
      op = ir[IW-1 -: 2];
      x  = int'(m_mem[ir[3*AW-1 -: AW]]);
      y  = int'(m_mem[ir[2*AW-1 -: AW]]);
      d  = int'(ir[AW-1:0]);
      r  = 0;
      if (op == c_halt) begin
        stop = 1'b1;
      end else begin
        if (op == c_add)      r = x + y;
        else if (op == c_sub) r = x - y;
        else                  r = x * y;
        m_mem[d]  = r[DW-1:0];
        m_instret = m_instret + 16'd1;
      end
    end
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 3000 && !halted; i++) tick();
    check({tag, " halted"}, 32'(halted), 32'd1);
  endtask

  task automatic run_prog(input string tag, output logic [15:0] delta);
    logic [15:0] c0;
    c0    = cycles;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_halt(tag);
    delta = cycles - c0;
  endtask

  task automatic rd(input int a, output logic [DW-1:0] v);
    dbg_addr = AW'(a);
    #1;
    v = dbg_data;
  endtask

  task automatic verify(input string tag);
    logic [DW-1:0] v;
    check({tag, " instret"}, 32'(instret), 32'(m_instret));
    check({tag, " busy"}, 32'(busy), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, v);
      check($sformatf("%s mem[%0d]", tag, a), 32'(v), 32'(m_mem[a]));
    end
  endtask

  task automatic gen_random();
    int n;
    prog_q.delete();
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 2));
      prog_q.push_back(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    prog_q.push_back(enc(c_halt, 0, 0, 0));
    // Trailing instruction must never execute.
    prog_q.push_back(enc(c_add, 1, 1, $urandom_range(0, 7)));
  endtask

  initial begin
    logic [15:0]   d_a, d_b, d_tmp;
    logic [DW-1:0] v;

    #2 rst = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset instret", 32'(instret), 32'd0);
    check("reset cycles", 32'(cycles), 32'd0);
    repeat (3) tick();
    @(negedge clk) rst = 1'b1;
    tick();
    check("idle cycles", 32'(cycles), 32'd0);

    for (int a = 0; a < DEPTH; a++) dload(a, DW'($urandom));

    // Case 1: ADD
    dload(1, 8'd5);
    dload(2, 8'd3);
    prog_q = '{enc(c_add, 1, 2, 3), enc(c_halt, 0, 0, 0)};
    load_prog();
    model_exec();
    run_prog("case1", d_tmp);
    verify("case1");
    rd(3, v);
    check("case1 mem3", 32'(v), 32'h08);
    check("case1 instret", 32'(instret), 32'd1);

    // Case 2: SUB wraps
    prog_q = '{enc(c_sub, 2, 1, 4), enc(c_halt, 0, 0, 0)};
    load_prog();
    model_exec();
    run_prog("case2", d_tmp);
    verify("case2");
    rd(4, v);
    check("case2 mem4", 32'(v), 32'hFE);

    // Case 3: MUL occupancy measured against the same program using ADD
    dload(1, 8'd20);
    dload(2, 8'd13);
    prog_q = '{enc(c_mul, 1, 2, 5), enc(c_add, 1, 1, 6), enc(c_halt, 0, 0, 0)};
    load_prog();
    model_exec();
    run_prog("case3", d_a);
    verify("case3");
    rd(5, v);
    check("case3 mem5", 32'(v), 32'h04);
    rd(6, v);
    check("case3 mem6", 32'(v), 32'h28);
    prog_q = '{enc(c_add, 1, 2, 5), enc(c_add, 1, 1, 6), enc(c_halt, 0, 0, 0)};
    load_prog();
    model_exec();
    run_prog("case3b", d_b);
    verify("case3b");
    check("case3 extra mul cycles", 32'(d_a - d_b), 32'(DW - 1));

    // Case 4: forwarding chain through MUL
    dload(1, 8'd5);
    dload(2, 8'd3);
    prog_q = '{enc(c_add, 1, 2, 3), enc(c_add, 3, 3, 4), enc(c_mul, 4, 1, 7),
               enc(c_add, 7, 1, 8), enc(c_halt, 0, 0, 0)};
    load_prog();
    model_exec();
    run_prog("case4", d_tmp);
    verify("case4");
    rd(4, v);
    check("case4 mem4", 32'(v), 32'h10);
    rd(7, v);
    check("case4 mem7", 32'(v), 32'h50);
    rd(8, v);
    check("case4 mem8", 32'(v), 32'h55);

    // Random programs; memory persists between runs
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 3; j++) dload($urandom_range(0, 7), DW'($urandom));
      end
      gen_random();
      load_prog();
      model_exec();
      run_prog($sformatf("rand%0d", k), d_tmp);
      verify($sformatf("rand%0d", k));
    end

    // Case 6: start/iload/dload during RUN are ignored
    dload(1, 8'd1);
    dload(2, 8'd7);
    dload(3, 8'd0);
    prog_q = '{enc(c_mul, 1, 2, 9), enc(c_add, 3, 1, 3), enc(c_add, 3, 1, 3),
               enc(c_halt, 0, 0, 0), enc(c_add, 3, 1, 3)};
    load_prog();
    model_exec();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("case6 busy at inject", 32'(busy), 32'd1);
    start      = 1'b1;
    iload_en   = 1'b1;
    iload_addr = '0;
    iload_data = enc(c_halt, 0, 0, 0);
    dload_en   = 1'b1;
    dload_addr = AW'(3);
    dload_data = 8'hEE;
    tick();
    start    = 1'b0;
    iload_en = 1'b0;
    dload_en = 1'b0;
    wait_halt("case6");
    verify("case6");
    model_exec();
    run_prog("case6 rerun", d_tmp);
    verify("case6 rerun");
    rd(3, v);
    check("case6 mem3", 32'(v), 32'h04);

    // Case 5: asynchronous reset in the middle of a MUL
    dload(1, 8'd20);
    dload(2, 8'd13);
    dload(5, 8'hAA);
    prog_q = '{enc(c_mul, 1, 2, 5), enc(c_halt, 0, 0, 0)};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("case5 busy before rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("case5 busy", 32'(busy), 32'd0);
    check("case5 halted", 32'(halted), 32'd0);
    check("case5 instret", 32'(instret), 32'd0);
    check("case5 cycles", 32'(cycles), 32'd0);
    m_instret = '0;
    repeat (12) tick();
    @(negedge clk) rst = 1'b1;
    tick();
    rd(5, v);
    check("case5 mem5 untouched", 32'(v), 32'hAA);
    verify("case5 abort");
    model_exec();
    run_prog("case5 rerun", d_tmp);
    verify("case5 rerun");
    rd(5, v);
    check("case5 rerun mem5", 32'(v), 32'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mini_core_pipe.md
MINI_CORE_PIPE -- requirements
Module: mini_core_pipe

Interface
REQ-001 Parameter DW, default 8: data word width.
REQ-002 Parameter AW, default 6: data-memory address width; data memory depth is 2^AW.
REQ-003 Parameter PW, default 5: program-counter width; instruction memory depth is 2^PW.
REQ-004 Derived IW = 2+3*AW is the instruction width; fields are op[IW-1:IW-2], src1, src2, dst (AW bits each, MSB to LSB).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset; rst is asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that begins execution at pc 0.
REQ-008 iload_en / iload_addr / iload_data  in  1 / PW / IW  instruction-memory write port.
REQ-009 dload_en / dload_addr / dload_data  in  1 / AW / DW  data-memory write port.
REQ-010 dbg_addr  in  AW  debug read address; dbg_data  out  DW  combinational data-memory read.
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 halted  out  1  high in HALTED.
REQ-013 instret  out  16  count of retired ADD/SUB/MUL; cycles  out  16  count of cycles spent in RUN+DRAIN; both wrap.

Function
REQ-014 Opcodes SHALL be 00 ADD, 01 SUB (src1-src2), 10 MUL, 11 HALT; results are modulo 2^DW, and MUL keeps the low DW bits.
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, HALTED: IDLE/HALTED+start->RUN (pc=0); HALT reaching LD->DRAIN; DRAIN with the pipe empty->HALTED.
REQ-016 The pipeline SHALL have four stages, IF (synchronous imem read), LD (operand read), EX, WB (dmem write on the WB clock edge), each with a valid bit.
REQ-017 ADD/SUB SHALL occupy EX for 1 cycle; MUL SHALL be an iterative shift-add taking exactly DW cycles in EX.
REQ-018 While a MUL is in EX, IF/LD/pc SHALL hold; EX SHALL then insert a bubble into WB until MUL completes; no instruction is lost or duplicated.
REQ-019 LD operands SHALL forward from the EX result (if EX is valid, done, and has a matching dst), else from WB (matching dst), else from memory; EX has priority.
REQ-020 If src matches the dst of an in-progress MUL, LD SHALL stall until that result is forwardable.
REQ-021 In DRAIN, fetch SHALL stop, and instructions behind HALT SHALL be squashed (valid cleared).
REQ-022 pc SHALL increment by 1 per fetch and wrap from 2^PW-1 to 0.
REQ-023 iload_en/dload_en SHALL be honoured only in IDLE or HALTED and ignored otherwise.
REQ-024 start SHALL be ignored in RUN/DRAIN.
REQ-025 instret SHALL increment at WB of each valid non-HALT instruction; HALT itself does not count.
REQ-026 Data-memory contents SHALL persist across HALTED->RUN.

Reset
REQ-027 On rst low, the block SHALL asynchronously enter IDLE with pc=0, all valid bits 0, MUL counter 0, busy=0, halted=0, instret=0, cycles=0.
REQ-028 rst mid-operation SHALL abort without any further dmem write; memory array contents are not reset.

Structure
REQ-029 Package mini_core_pkg SHALL hold the opcode constants, FSM state enum, and IW derivation function.
REQ-030 The iterative multiplier SHALL be sub-module mc_mul_iter (start, a, b -> done, p), DW-parametrised.
REQ-031 Instruction and data memories SHALL be inline arrays inside mini_core_pipe.

Verification (DW=8, AW=6, PW=5)
REQ-032 Case 1: mem[1]=5, mem[2]=3, prog ADD 1,2->3; HALT; start -> mem[3]=0x08, halted=1, instret=1.
REQ-033 Case 2: SUB 2,1->4 with mem[1]=5, mem[2]=3 -> mem[4]=0xFE.
REQ-034 Case 3: mem[1]=20, mem[2]=13, MUL 1,2->5; ADD 1,1->6 -> mem[5]=0x04, mem[6]=0x28, and EX is held for exactly 8 cycles.
REQ-035 Case 4: back-to-back ADD 1,2->3; ADD 3,3->4; MUL 4,1->7; ADD 7,1->8 with mem[1]=5, mem[2]=3 -> mem[4]=0x10, mem[7]=0x50, mem[8]=0x55 (forwarding and MUL-stall paths).
REQ-036 Case 5: rst low during MUL cycle 4 -> IDLE, busy=0, dst unchanged, instret=0.
REQ-037 Case 6: start pulse and iload_en during RUN -> both ignored; imem is unchanged and pc is not reset.
